// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
//
// Purpose: latches decoded ID fields and register-file operands, extends the
// 16-bit immediate at capture, and presents forwarded A/B operands to the
// EX-stage ALU. Detects load-use hazards and inserts bubbles. Honours
// downstream stall and branch flush.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   stall, flush               downstream freeze / branch squash
//   id_*                       decoded instruction fields and operands from ID
//   exmem_*, memwb_*           forwarding sources (write enable, dest, value)
//   ex_valid, ex_a, ex_b       EX instruction valid and final ALU operands
//   ex_store_data              forwarded rt value for stores
//   ex_alu_op, ex_dest         ALU function and destination register
//   ex_reg_write/mem_read/mem_write  registered control bits
//   load_use_stall             to IF/ID: hold PC and IF/ID register
module id_ex_operand_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [15:0]   id_imm16,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic          id_uses_rt,
   input  logic [3:0]    id_alu_op,
   input  logic          id_alu_src,
   input  logic          id_sign_ext,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          exmem_reg_write,
   input  logic [RW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_reg_write,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_result,
   output logic          ex_valid,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [DW-1:0] ex_store_data,
   output logic [3:0]    ex_alu_op,
   output logic [RW-1:0] ex_dest,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          load_use_stall
);

   logic          valid_q;
   logic [RW-1:0] rs_q, rt_q, rd_q;
   logic [DW-1:0] rs_data_q, rt_data_q, imm32_q;
   logic [3:0]    alu_op_q;
   logic          alu_src_q, reg_write_q, mem_read_q, mem_write_q;

   logic [DW-1:0] imm32;
   logic          wb_id_rs, wb_id_rt, wb_rs_q, wb_rt_q;
   logic [DW-1:0] fwd_rs, fwd_rt;

   assign imm32 = id_sign_ext ? {{(DW-16){id_imm16[15]}}, id_imm16}
                              : {{(DW-16){1'b0}}, id_imm16};

   // The register file reads before it writes, so a same-cycle MEM/WB write
   // must be captured here (write-through) or re-applied while held (refresh).
   assign wb_id_rs = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs);
   assign wb_id_rt = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rt);
   assign wb_rs_q  = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q);
   assign wb_rt_q  = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q);

   // The load in EX has no data yet; a dependent ID instruction must wait.
   assign load_use_stall = !flush && valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                           ((rd_q == id_rs) || (id_uses_rt && (rd_q == id_rt)));

   always_ff @(posedge clk) begin
      if (reset || flush || (!stall && load_use_stall)) begin
         valid_q     <= 1'b0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm32_q     <= '0;
         alu_op_q    <= '0;
         alu_src_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else if (stall) begin
         if (wb_rs_q) rs_data_q <= memwb_result;
         if (wb_rt_q) rt_data_q <= memwb_result;
      end else begin
         valid_q     <= id_valid;
         rs_q        <= id_rs;
         rt_q        <= id_rt;
         rd_q        <= id_rd;
         rs_data_q   <= wb_id_rs ? memwb_result : id_rs_data;
         rt_data_q   <= wb_id_rt ? memwb_result : id_rt_data;
         imm32_q     <= imm32;
         alu_op_q    <= id_alu_op;
         alu_src_q   <= id_alu_src;
         reg_write_q <= id_valid && id_reg_write;
         mem_read_q  <= id_valid && id_mem_read;
         mem_write_q <= id_valid && id_mem_write;
      end
   end

   // EX/MEM holds the newer value, so it wins over MEM/WB. r0 is never forwarded.
   always_comb begin
      fwd_rs = rs_data_q;
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q))
         fwd_rs = exmem_result;
      else if (wb_rs_q)
         fwd_rs = memwb_result;

      fwd_rt = rt_data_q;
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q))
         fwd_rt = exmem_result;
      else if (wb_rt_q)
         fwd_rt = memwb_result;
   end

   assign ex_valid      = valid_q;
   assign ex_a          = fwd_rs;
   assign ex_b          = alu_src_q ? imm32_q : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_alu_op     = alu_op_q;
   assign ex_dest       = rd_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

   typedef struct packed {
      logic        reset, stall, flush, id_valid;
      logic [31:0] rs_data, rt_data;
      logic [15:0] imm16;
      logic [4:0]  rs, rt, rd;
      logic        uses_rt;
      logic [3:0]  alu_op;
      logic        alu_src, sign_ext, rw, mr, mw;
      logic        exw;
      logic [4:0]  exrd;
      logic [31:0] exres;
      logic        mww;
      logic [4:0]  mwrd;
      logic [31:0] mwres;
   } in_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] a, b, sd;
      logic [4:0]  dest;
      logic        rw, mr, lus;
   } exp_t;

   typedef struct packed {
      in_t  i;
      exp_t e;
      logic chk, dchk;
   } vec_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rs_data, rt_data, imm32;
      logic [3:0]  alu_op;
      logic        alu_src, rw, mr, mw;
   } st_t;

   logic        clk = 1'b0;
   logic        reset, stall, flush, id_valid;
   logic [31:0] id_rs_data, id_rt_data;
   logic [15:0] id_imm16;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rt;
   logic [3:0]  id_alu_op;
   logic        id_alu_src, id_sign_ext, id_reg_write, id_mem_read, id_mem_write;
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_result;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_result;
   logic        ex_valid;
   logic [31:0] ex_a, ex_b, ex_store_data;
   logic [3:0]  ex_alu_op;
   logic [4:0]  ex_dest;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
      .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_sign_ext(id_sign_ext),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
      .ex_alu_op(ex_alu_op), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
   );

   task automatic drive(input in_t x);
      reset = x.reset; stall = x.stall; flush = x.flush; id_valid = x.id_valid;
      id_rs_data = x.rs_data; id_rt_data = x.rt_data; id_imm16 = x.imm16;
      id_rs = x.rs; id_rt = x.rt; id_rd = x.rd; id_uses_rt = x.uses_rt;
      id_alu_op = x.alu_op; id_alu_src = x.alu_src; id_sign_ext = x.sign_ext;
      id_reg_write = x.rw; id_mem_read = x.mr; id_mem_write = x.mw;
      exmem_reg_write = x.exw; exmem_rd = x.exrd; exmem_result = x.exres;
      memwb_reg_write = x.mww; memwb_rd = x.mwrd; memwb_result = x.mwres;
   endtask

   task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, expv);
      end
   endtask

   // Reference model: newest writer of a register supplies its value.
   function automatic logic [31:0] m_operand(input logic [4:0] r, input logic [31:0] stored, input in_t x);
      logic        w[2];
      logic [4:0]  d[2];
      logic [31:0] v[2];
      logic        found;
      logic [31:0] res;
      w[0] = x.exw; d[0] = x.exrd; v[0] = x.exres;
      w[1] = x.mww; d[1] = x.mwrd; v[1] = x.mwres;
      found = 1'b0;
      res = stored;
      for (int p = 0; p < 2; p++)
         if (!found && w[p] && r != 0 && d[p] == r) begin
            found = 1'b1;
            res = v[p];
         end
      return res;
   endfunction

   function automatic logic m_wb(input logic [4:0] r, input in_t x);
      return x.mww && x.mwrd != 0 && x.mwrd == r;
   endfunction

   function automatic logic m_lus(input st_t s, input in_t x);
      logic [4:0] srcs[$];
      logic hit;
      if (x.flush || !(s.valid && s.mr && s.rd != 0 && x.id_valid)) return 1'b0;
      srcs.push_back(x.rs);
      if (x.uses_rt) srcs.push_back(x.rt);
      hit = 1'b0;
      foreach (srcs[k]) if (srcs[k] == s.rd) hit = 1'b1;
      return hit;
   endfunction

   function automatic st_t m_next(input st_t s, input in_t x);
      st_t n;
      n = s;
      if (x.reset || x.flush) n = '0;
      else if (x.stall) begin
         if (m_wb(s.rs, x)) n.rs_data = x.mwres;
         if (m_wb(s.rt, x)) n.rt_data = x.mwres;
      end else if (m_lus(s, x)) n = '0;
      else begin
         n.valid   = x.id_valid;
         n.rs      = x.rs;
         n.rt      = x.rt;
         n.rd      = x.rd;
         n.rs_data = m_wb(x.rs, x) ? x.mwres : x.rs_data;
         n.rt_data = m_wb(x.rt, x) ? x.mwres : x.rt_data;
         n.imm32   = (x.sign_ext && x.imm16 >= 16'h8000) ? 32'(x.imm16) + 32'hFFFF0000 : 32'(x.imm16);
         n.alu_op  = x.alu_op;
         n.alu_src = x.alu_src;
         n.rw      = x.id_valid & x.rw;
         n.mr      = x.id_valid & x.mr;
         n.mw      = x.id_valid & x.mw;
      end
      return n;
   endfunction

   vec_t vq[$];
   vec_t t;
   st_t  st;
   in_t  rin;
   logic [31:0] rt_fwd;

   initial begin
      // ---- directed table ----
      t = '0;
      t.i = '{reset:1, stall:0, flush:0, id_valid:1, rs_data:32'hDEADBEEF, rt_data:32'hCAFEF00D,
              imm16:16'hFFFF, rs:1, rt:2, rd:3, uses_rt:1, alu_op:4'hF, alu_src:1, sign_ext:1,
              rw:1, mr:1, mw:1, exw:1, exrd:1, exres:32'h12345678, mww:1, mwrd:2, mwres:32'h87654321};
      vq.push_back(t);
      t.chk = 1; t.dchk = 1;
      vq.push_back(t);
      t = '0; t.chk = 1; t.dchk = 1; vq.push_back(t);
      // immediate extension
      t = '0; t.chk = 1; t.dchk = 1;
      t.i.id_valid = 1; t.i.alu_src = 1; t.i.sign_ext = 1; t.i.imm16 = 16'hFFFE; t.i.rd = 3; t.i.rw = 1;
      vq.push_back(t);
      t.i.sign_ext = 0;
      t.e.valid = 1; t.e.b = 32'hFFFFFFFE; t.e.dest = 3; t.e.rw = 1;
      vq.push_back(t);
      t.i = '0; t.e.b = 32'h0000FFFE;
      vq.push_back(t);
      // forwarding priority
      t = '0; t.chk = 1; t.dchk = 1;
      t.i.id_valid = 1; t.i.rs = 5; t.i.rs_data = 32'h11; t.i.rd = 6; t.i.rw = 1;
      vq.push_back(t);
      t.i = '0; t.i.stall = 1; t.i.exw = 1; t.i.exres = 32'h22; t.i.mww = 1; t.i.mwres = 32'h33;
      t.e.valid = 1; t.e.a = 32'h11; t.e.dest = 6; t.e.rw = 1;
      vq.push_back(t);
      t.i.exrd = 5; t.i.mwrd = 5; t.e.a = 32'h22;
      vq.push_back(t);
      t.i.exw = 0; t.e.a = 32'h33;
      vq.push_back(t);
      t.i = '0;
      vq.push_back(t);
      // load-use
      t = '0; t.chk = 1; t.dchk = 1;
      t.i.id_valid = 1; t.i.rs = 2; t.i.rs_data = 32'h100; t.i.rd = 8; t.i.rw = 1; t.i.mr = 1;
      t.i.alu_src = 1; t.i.sign_ext = 1; t.i.imm16 = 16'h4;
      vq.push_back(t);
      t.i = '0; t.i.id_valid = 1; t.i.rs = 8; t.i.rs_data = 32'h55; t.i.rt = 3; t.i.rt_data = 32'h7;
      t.i.rd = 10; t.i.uses_rt = 1; t.i.rw = 1;
      t.e = '{valid:1, a:32'h100, b:32'h4, sd:32'h0, dest:8, rw:1, mr:1, lus:1};
      vq.push_back(t);
      t.dchk = 0; t.e = '0;
      vq.push_back(t);
      t.i = '0; t.i.mww = 1; t.i.mwrd = 8; t.i.mwres = 32'h1234; t.dchk = 1;
      t.e = '{valid:1, a:32'h1234, b:32'h7, sd:32'h7, dest:10, rw:1, mr:0, lus:0};
      vq.push_back(t);
      // stall refresh
      t = '0; t.chk = 1; t.dchk = 1;
      t.i.id_valid = 1; t.i.rs = 4; t.i.rs_data = 32'h44; t.i.rt = 9; t.i.rt_data = 32'h99; t.i.rd = 12;
      t.i.uses_rt = 1; t.i.mw = 1; t.i.alu_src = 1; t.i.imm16 = 16'h10;
      vq.push_back(t);
      t.i = '0; t.i.stall = 1; t.i.id_valid = 1; t.i.rs = 1; t.i.rt = 2; t.i.rd = 3; t.i.rw = 1;
      t.i.mww = 1; t.i.mwrd = 9; t.i.mwres = 32'hABCD;
      t.e = '{valid:1, a:32'h44, b:32'h10, sd:32'hABCD, dest:12, rw:0, mr:0, lus:0};
      vq.push_back(t);
      t.i.mww = 0; vq.push_back(t); vq.push_back(t);
      t.i = '0; vq.push_back(t);
      // flush beats stall; flush masks load_use_stall
      t = '0; t.chk = 1; t.dchk = 1;
      t.i.id_valid = 1; t.i.rs = 1; t.i.rs_data = 32'h5; t.i.rd = 2; t.i.rw = 1;
      vq.push_back(t);
      t.i.flush = 1; t.i.stall = 1; t.e.valid = 1; t.e.a = 32'h5; t.e.dest = 2; t.e.rw = 1;
      vq.push_back(t);
      t.i.flush = 0; t.e = '0;
      vq.push_back(t);
      t.i = '0; t.i.id_valid = 1; t.i.rs = 2; t.i.rd = 8; t.i.rw = 1; t.i.mr = 1;
      vq.push_back(t);
      t.i = '0; t.i.flush = 1; t.i.id_valid = 1; t.i.rs = 8; t.i.rd = 9; t.i.rw = 1;
      t.e.valid = 1; t.e.dest = 8; t.e.rw = 1; t.e.mr = 1;
      vq.push_back(t);
      // reset mid-stall
      t = '0; t.chk = 1; t.dchk = 1;
      t.i.id_valid = 1; t.i.rs = 3; t.i.rs_data = 32'h77; t.i.rd = 4; t.i.rw = 1;
      vq.push_back(t);
      t.i.stall = 1; t.e.valid = 1; t.e.a = 32'h77; t.e.dest = 4; t.e.rw = 1;
      vq.push_back(t);
      t.i.reset = 1; vq.push_back(t);
      t.i.reset = 0; t.e = '0; vq.push_back(t);

      for (int n = 0; n < vq.size(); n++) begin
         drive(vq[n].i);
         #1;
         if (vq[n].chk) begin
            cmp("valid", n, 32'(ex_valid), 32'(vq[n].e.valid));
            cmp("reg_write", n, 32'(ex_reg_write), 32'(vq[n].e.rw));
            cmp("mem_read", n, 32'(ex_mem_read), 32'(vq[n].e.mr));
            cmp("load_use_stall", n, 32'(load_use_stall), 32'(vq[n].e.lus));
            if (vq[n].dchk) begin
               cmp("ex_a", n, ex_a, vq[n].e.a);
               cmp("ex_b", n, ex_b, vq[n].e.b);
               cmp("store_data", n, ex_store_data, vq[n].e.sd);
               cmp("dest", n, 32'(ex_dest), 32'(vq[n].e.dest));
            end
         end
         @(posedge clk);
         #1;
      end

      // ---- randomized run against the reference model ----
      st = '0;
      for (int n = 0; n < 1500; n++) begin
         rin.reset    = (n == 0) || ($urandom_range(0, 49) == 0);
         rin.stall    = ($urandom_range(0, 5) == 0);
         rin.flush    = ($urandom_range(0, 9) == 0);
         rin.id_valid = ($urandom_range(0, 3) != 0);
         rin.rs_data  = $urandom;
         rin.rt_data  = $urandom;
         rin.imm16    = 16'($urandom);
         rin.rs       = 5'($urandom_range(0, 3));
         rin.rt       = 5'($urandom_range(0, 3));
         rin.rd       = 5'($urandom_range(0, 3));
         rin.uses_rt  = 1'($urandom);
         rin.alu_op   = 4'($urandom);
         rin.alu_src  = 1'($urandom);
         rin.sign_ext = 1'($urandom);
         rin.rw       = 1'($urandom);
         rin.mr       = 1'($urandom);
         rin.mw       = 1'($urandom);
         rin.exw      = 1'($urandom);
         rin.exrd     = 5'($urandom_range(0, 3));
         rin.exres    = $urandom;
         rin.mww      = 1'($urandom);
         rin.mwrd     = 5'($urandom_range(0, 3));
         rin.mwres    = $urandom;
         drive(rin);
         #1;
         if (n > 0) begin
            rt_fwd = m_operand(st.rt, st.rt_data, rin);
            cmp("r_valid", n, 32'(ex_valid), 32'(st.valid));
            cmp("r_ex_a", n, ex_a, m_operand(st.rs, st.rs_data, rin));
            cmp("r_ex_b", n, ex_b, st.alu_src ? st.imm32 : rt_fwd);
            cmp("r_store_data", n, ex_store_data, rt_fwd);
            cmp("r_alu_op", n, 32'(ex_alu_op), 32'(st.alu_op));
            cmp("r_dest", n, 32'(ex_dest), 32'(st.rd));
            cmp("r_reg_write", n, 32'(ex_reg_write), 32'(st.rw));
            cmp("r_mem_read", n, 32'(ex_mem_read), 32'(st.mr));
            cmp("r_mem_write", n, 32'(ex_mem_write), 32'(st.mw));
            cmp("r_load_use", n, 32'(load_use_stall), 32'(m_lus(st, rin)));
         end
         st = m_next(st, rin);
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
